// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } adder_state_t;

  // Number of CHUNK-wide slices in a WIDTH-bit operand.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index counter; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[CHUNK];
  assign o_cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle ripple-carry adder: adds CHUNK bits per clock with a registered
// inter-chunk carry, behind valid/ready handshakes on input and output.
// Optional feature macro: ADDER_SUB_EN (adds in_sub port, a - b as a + ~b + 1).
module multicycle_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = idx_width(NCHUNK);

  // Operand width must split evenly into chunks.
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("multicycle_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  adder_state_t     r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum_chunk;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_b_in;
  logic             w_carry_in;

  // Select the operand slice addressed by the chunk index.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  // Operand B and carry seed as latched on accept (inverted/seeded for subtract).
`ifdef ADDER_SUB_EN
  assign w_b_in     = in_sub ? ~in_b : in_b;
  assign w_carry_in = in_sub ? 1'b1 : in_cin;
`else
  assign w_b_in     = in_b;
  assign w_carry_in = in_cin;
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_sum_chunk),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  // Control FSM, operand/carry/index state and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= w_b_in;
            r_carry    <= w_carry_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
              r_sum[k*CHUNK +: CHUNK] <= w_sum_chunk;
            end
          end
          r_carry <= w_cout;
          if (r_idx == IDXW'(NCHUNK - 1)) begin
            r_cout      <= w_cout;
            r_ovf       <= w_cout ^ w_cmsb;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

endmodule
